// File: rtl/hs32_user_project_wrapper.sv
// HS32 Caravel user-area top: Wishbone-loadable word SRAM shared with the
// HS32 core, with logic-analyzer bits for core reset and SRAM ownership.
`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

// Execute stage of the reduced HS32 core; raises a sticky fault on an
// opcode it does not implement.
module hs32_exec (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        vld_i,
    input  logic [31:0] instr_i,
    output logic        branch_o,
    output logic [31:0] target_o,
    output logic        fault_o
);
    logic       fault;
    logic       known;
    logic [7:0] opcode;
    logic       unused_fields;

    assign opcode        = instr_i[31:24];
    assign known         = (opcode == 8'h24) || (opcode == 8'h34) ||
                           (opcode == 8'h14) || (opcode == 8'h50);
    assign branch_o      = vld_i && (opcode == 8'h50);
    assign target_o      = {14'b0, instr_i[15:0], 2'b00};
    assign fault_o       = fault;
    assign unused_fields = ^instr_i[23:16];

    // Sticky fault flag, cleared only by core reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault <= 1'b0;
        end else if (vld_i && !known) begin
            fault <= 1'b1;
        end
    end
endmodule

// Fetch/execute sequencer: fetches one word, executes it, repeats.
module hs32_cpu (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] addr_o,
    output logic [31:0] dtw_o,
    input  logic [31:0] dtr_i,
    output logic        rw_o,
    output logic        stb_o,
    input  logic        ack_i,
    input  logic [23:0] interrupts_i,
    output logic        fault_o
);
    typedef enum logic [0:0] {S_FETCH, S_EXEC} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        branch;
    logic [31:0] target;
    logic        unused_irq;

    assign addr_o     = pc_q;
    assign dtw_o      = '0;
    assign rw_o       = 1'b0;
    assign unused_irq = ^interrupts_i;

    hs32_exec EXEC (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .vld_i   (state_q == S_EXEC),
        .instr_i (ir_q),
        .branch_o(branch),
        .target_o(target),
        .fault_o (fault_o)
    );

    // State and PC registers; execution restarts at address 0 after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
        ir_q <= ir_d;
    end

    // Next-state: hold strobe until the memory acks, then execute one cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        stb_o   = 1'b0;
        case (state_q)
            S_FETCH: begin
                stb_o = 1'b1;
                if (ack_i) begin
                    ir_d    = dtr_i;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_d    = branch ? target : pc_q + 32'd4;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end
endmodule

// Core shell so the execute-stage fault sits at core1.core.EXEC.fault.
module hs32_core (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] addr_o,
    output logic [31:0] dtw_o,
    input  logic [31:0] dtr_i,
    output logic        rw_o,
    output logic        stb_o,
    input  logic        ack_i,
    input  logic [23:0] interrupts_i,
    output logic        fault_o
);
    hs32_cpu core (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .addr_o      (addr_o),
        .dtw_o       (dtw_o),
        .dtr_i       (dtr_i),
        .rw_o        (rw_o),
        .stb_o       (stb_o),
        .ack_i       (ack_i),
        .interrupts_i(interrupts_i),
        .fault_o     (fault_o)
    );
endmodule

module hs32_user_project_wrapper #(
    parameter int MEM_WORDS = 1024,
    parameter int IO_PADS   = `MPRJ_IO_PADS
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_dat_i,
    input  logic [31:0]         wbs_adr_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic [127:0]        la_data_in,
    output logic [127:0]        la_data_out,
    input  logic [127:0]        la_oen,
    input  logic [IO_PADS-1:0]  io_in,
    output logic [IO_PADS-1:0]  io_out,
    output logic [IO_PADS-1:0]  io_oeb,
    inout  wire  [IO_PADS-8:0]  analog_io,
    input  logic                user_clock2
);
    localparam int AW = $clog2(MEM_WORDS);

    // Control decode
    logic run, rq, core_rst_d, core_rst_q;
    assign run        = la_data_in[1] & ~la_oen[1];
    assign rq         = la_data_in[0] & ~la_oen[0];
    assign core_rst_d = wb_rst_i | rq | ~run;

    // Core memory port
    logic [31:0] core_addr, core_dtw, core_dtr;
    logic        core_rw, core_stb, core_fault;
    logic        core_acc, core_in_range, core_hit;
    logic        core_ack_q, core_rd_ok_q;

    // Wishbone side
    logic wb_acc, wb_in_range, wb_hit;
    logic ack_q, wb_rd_ok_q;

    // SRAM single port
    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] mem_idx;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wd;
    logic [31:0]   mem_rd_q;

    logic unused_ok;
    assign unused_ok = ^{io_in, user_clock2, analog_io, la_data_in[127:2],
                         la_oen[127:2], core_addr[1:0]};

    assign wb_acc      = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign wb_in_range = wbs_adr_i[31:2] < 30'(MEM_WORDS);
    assign wb_hit      = wb_acc & ~run & wb_in_range;

    assign core_acc      = core_stb & ~core_ack_q;
    assign core_in_range = core_addr[31:2] < 30'(MEM_WORDS);
    assign core_hit      = core_acc & run & core_in_range;

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = (ack_q & wb_rd_ok_q) ? mem_rd_q : 32'd0;
    assign core_dtr  = (core_ack_q & core_rd_ok_q) ? mem_rd_q : 32'd0;

    assign la_data_out = {125'd0, core_rst_q, run, core_fault};
    assign io_out      = '0;
    assign io_oeb      = '1;

    // Registered core reset: LA/reset changes reach the core one edge later.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            core_rst_q <= 1'b1;
        end else begin
            core_rst_q <= core_rst_d;
        end
    end

    // Wishbone ack: single-cycle pulse after each accepted access.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q      <= 1'b0;
            wb_rd_ok_q <= 1'b0;
        end else begin
            ack_q      <= wb_acc;
            wb_rd_ok_q <= wb_hit & ~wbs_we_i;
        end
    end

    // Core ack: one-cycle registered response, held off while core is in reset.
    always_ff @(posedge wb_clk_i) begin
        if (core_rst_q) begin
            core_ack_q   <= 1'b0;
            core_rd_ok_q <= 1'b0;
        end else begin
            core_ack_q   <= core_acc;
            core_rd_ok_q <= core_hit & ~core_rw;
        end
    end

    // Port select: ownership follows run, so only one side ever drives the SRAM.
    always_comb begin
        mem_idx = wbs_adr_i[AW+1:2];
        mem_we  = wb_hit & wbs_we_i;
        mem_be  = wbs_sel_i;
        mem_wd  = wbs_dat_i;
        if (run) begin
            mem_idx = core_addr[AW+1:2];
            mem_we  = core_hit & core_rw;
            mem_be  = 4'hF;
            mem_wd  = core_dtw;
        end
    end

    // SRAM array with byte enables; contents deliberately survive reset.
    always_ff @(posedge wb_clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && mem_be[b]) begin
                mem[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
            end
        end
        mem_rd_q <= mem[mem_idx];
    end

    hs32_core core1 (
        .clk_i       (wb_clk_i),
        .rst_i       (core_rst_q),
        .addr_o      (core_addr),
        .dtw_o       (core_dtw),
        .dtr_i       (core_dtr),
        .rw_o        (core_rw),
        .stb_o       (core_stb),
        .ack_i       (core_ack_q),
        .interrupts_i(24'd0),
        .fault_o     (core_fault)
    );
endmodule

// File: tb/tb_hs32_user_project_wrapper.sv
// Scoreboard bench for hs32_user_project_wrapper: driver queues expected
// Wishbone read data, monitor pops on every ack.
module tb_hs32_user_project_wrapper;
    localparam int IO_PADS = 38;

    logic               clk = 1'b0;
    logic               rst;
    logic               stb, cyc, we;
    logic [3:0]         sel;
    logic [31:0]        dat_i, adr;
    logic               ack;
    logic [31:0]        dat_o;
    logic [127:0]       la_in, la_out, la_oen;
    logic [IO_PADS-1:0] io_in, io_out, io_oeb;
    wire  [IO_PADS-8:0] analog_io;
    logic               uclk2;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic        prev_ack = 1'b0;
    logic        fault_seen = 1'b0;
    logic [31:0] prog [5] = '{32'h2400CAFE, 32'h24100005, 32'h34010001,
                              32'h14210001, 32'h50000000};

    hs32_user_project_wrapper dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_dat_i  (dat_i),
        .wbs_adr_i  (adr),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_o),
        .la_data_in (la_in),
        .la_data_out(la_out),
        .la_oen     (la_oen),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_oeb     (io_oeb),
        .analog_io  (analog_io),
        .user_clock2(uclk2)
    );

    always #5 clk = ~clk;

    // Monitor: every ack pops one expected word; acks never back-to-back.
    always @(negedge clk) begin
        if (ack) begin
            checks++;
            if (prev_ack) begin
                errors++;
                $display("FAIL ack_twice: ack high two cycles in a row");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: got ack with data %h, none expected", dat_o);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                if (dat_o !== e) begin
                    errors++;
                    $display("FAIL wb_data: got %h expected %h", dat_o, e);
                end
            end
        end
        prev_ack <= ack;
        if (!rst && dut.core1.core.EXEC.fault) fault_seen <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // One access, strobe held a single cycle; ack must follow on the next cycle.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, input logic [31:0] e);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
        exp_q.push_back(e);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check("ack_latency", {31'd0, ack}, 32'd1);
        @(posedge clk);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        dat_i = '0; adr = '0; la_in = 128'd1; la_oen = '0; io_in = '0; uclk2 = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_ack", {31'd0, ack}, 32'd0);
            check("rst_dat", dat_o, 32'd0);
            check("io_oeb", {26'd0, io_oeb}, {26'd0, {IO_PADS{1'b1}}});
            check("io_out", {26'd0, io_out}, 32'd0);
        end
        check("rst_core_rst", {31'd0, la_out[2]}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; la_in = 128'd0;

        // Program load and read-back
        for (int i = 0; i < 5; i++) wb_xfer(1'b1, 32'(i * 4), 4'hF, prog[i], 32'd0);
        for (int i = 0; i < 5; i++) wb_xfer(1'b0, 32'(i * 4), 4'hF, 32'd0, prog[i]);
        wb_xfer(1'b0, 32'h7, 4'hF, 32'd0, 32'h24100005);

        // Single-byte write
        wb_xfer(1'b1, 32'h0, 4'b0010, 32'hAABBCCDD, 32'd0);
        wb_xfer(1'b0, 32'h0, 4'hF, 32'd0, 32'h2400CCFE);
        wb_xfer(1'b1, 32'h0, 4'hF, prog[0], 32'd0);

        // Masked run bit is ignored
        @(posedge clk); #1;
        la_in = 128'd2; la_oen = 128'd2;
        @(negedge clk);
        check("oen_masks_run", {31'd0, la_out[1]}, 32'd0);
        la_oen = '0;

        // Core owns SRAM: WB reads 0, writes dropped
        cycles(2);
        @(negedge clk);
        check("core_released", {30'd0, la_out[2:1]}, 32'd1);
        wb_xfer(1'b0, 32'h0, 4'hF, 32'd0, 32'd0);
        wb_xfer(1'b1, 32'h0, 4'hF, 32'h12345678, 32'd0);
        @(posedge clk); #1;
        la_in = 128'd0;
        cycles(2);
        wb_xfer(1'b0, 32'h0, 4'hF, 32'd0, prog[0]);

        // Second reset with program resident, then long run
        @(posedge clk); #1;
        la_in = 128'd2;
        cycles(20);
        #1;
        la_in = 128'd3; rst = 1'b1;
        cycles(10);
        @(negedge clk);
        check("rst2_core_rst", {31'd0, la_out[2]}, 32'd1);
        check("rst2_ack", {31'd0, ack}, 32'd0);
        @(posedge clk); #1;
        la_in = 128'd2; rst = 1'b0;
        cycles(1000);
        @(negedge clk);
        check("fault_never", {31'd0, fault_seen}, 32'd0);
        check("la_fault", {31'd0, la_out[0]}, 32'd0);
        check("la_run", {31'd0, la_out[1]}, 32'd1);
        @(posedge clk); #1;
        la_in = 128'd0;
        cycles(2);
        for (int i = 0; i < 5; i++) wb_xfer(1'b0, 32'(i * 4), 4'hF, 32'd0, prog[i]);

        // Out-of-range accesses and last in-range word
        wb_xfer(1'b1, 32'h4000, 4'hF, 32'hDEADBEEF, 32'd0);
        wb_xfer(1'b0, 32'h4000, 4'hF, 32'd0, 32'd0);
        wb_xfer(1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, 32'd0);
        for (int i = 0; i < 5; i++) wb_xfer(1'b0, 32'(i * 4), 4'hF, 32'd0, prog[i]);
        wb_xfer(1'b1, 32'hFFC, 4'hF, 32'h11223344, 32'd0);
        wb_xfer(1'b0, 32'hFFC, 4'hF, 32'd0, 32'h11223344);

        cycles(3);
        check("pending_acks", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hs32_user_project_wrapper.md
Name: hs32_user_project_wrapper

Overview:
- Caravel user-area top for the HS32 core.
- Owns a single-port word SRAM that the management SoC loads over a Wishbone slave port.
- Logic-analyzer (LA) bits hold the core in reset and hand SRAM ownership from Wishbone to the core.
- Instantiates the existing HS32 core block as instance `core1`. The core's internal execute-stage `fault` flag stays reachable hierarchically at `core1.core.EXEC.fault`.

Parameters:
- MEM_WORDS, 1024: SRAM depth in 32-bit words (4 KiB), mapped at byte address 0.
- IO_PADS, `MPRJ_IO_PADS (38): width of the io buses.

Ports:
- wb_clk_i  in  1  sole clock, rising edge
- wb_rst_i  in  1  reset, synchronous, active-high
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  byte address
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- la_data_in  in  128  LA control; bit0 = core reset request, bit1 = run (core owns SRAM)
- la_data_out  out  128  LA status
- la_oen  in  128  LA bit n is honoured only when la_oen[n]=0; otherwise it reads as 0
- io_in  in  IO_PADS  unused
- io_out  out  IO_PADS  driven 0
- io_oeb  out  IO_PADS  driven all-1 (all pads input)
- analog_io  inout  IO_PADS-7  unconnected
- user_clock2  in  1  unused

Behaviour:
- Control bits:
  - run = la_data_in[1] & ~la_oen[1]
  - rq = la_data_in[0] & ~la_oen[0]
  - core_rst = wb_rst_i | rq | ~run
  - core_rst is registered: it takes effect on the next clock edge.
  - While core_rst=1 the core is held in reset; it fetches from address 0 after release.
- Ownership:
  - run=0: Wishbone owns the SRAM.
  - run=1: the core owns the SRAM.
  - Ownership follows run combinationally. There is no arbitration and no simultaneous access.
- Wishbone slave:
  - An access is accepted in a cycle with cyc & stb & ~ack_r.
  - wbs_ack_o is a registered single-cycle pulse on the following cycle; it is never high two cycles in a row.
  - Dropping stb after one cycle, before ack, still completes the accepted access.
  - Word index = adr[31:2]; adr[1:0] is ignored.
  - Write with run=0 and index < MEM_WORDS: update each byte whose sel bit is set.
  - Read: wbs_dat_o holds the SRAM word during the ack cycle and 0 otherwise.
  - Out-of-range index, or any access while run=1: acked normally; writes are dropped and reads return 0.
- Core memory port (addr 32, dtw 32, dtr 32, rw, stb, ack):
  - One-cycle registered ack.
  - In-range accesses hit the SRAM as full 32-bit words.
  - Out-of-range accesses are acked with dtr=0 and writes are discarded.
  - Core interrupt inputs are tied to 0.
- la_data_out:
  - bit0 = core fault
  - bit1 = run
  - bit2 = core_rst
  - all other bits 0
- Reset (wb_rst_i):
  - wbs_ack_o=0, wbs_dat_o=0, core held in reset.
  - SRAM contents are NOT cleared, so a program survives a second reset.
- Reset mid-transaction: a pending ack is dropped and the master must retry.

Test Plan:
- Reset with la_data_in=1 for 10 cycles, then release:
  - wbs_ack_o=0, io_oeb=all-1, io_out=0 throughout.
  - la_data_out[2]=1.
- With la_data_in=0, write 0x2400CAFE, 0x24100005, 0x34010001, 0x14210001, 0x50000000 to addresses 0x0, 0x4, 0x8, 0xC, 0x10, with stb high for one cycle per access:
  - exactly one ack per write.
  - Read-back returns the same words.
- Write 0xAABBCCDD to address 0x0 with sel=4'b0010 over a stored 0x2400CAFE -> word reads 0x2400CCFE.
- Set la_data_in=2'b10:
  - core leaves reset within 2 cycles.
  - A Wishbone read of 0x0 is acked with data 0.
  - A Wishbone write of 0x0 is dropped (verify after run is cleared).
- Load the 5-word program, set la=10, pulse la=11 with wb_rst_i for 10 cycles, return to la=10, then run 1000 cycles:
  - SRAM program is intact after the second reset.
  - `core1.core.EXEC.fault` stays 0.
  - la_data_out[0]=0.
- Wishbone write to address 0x4000 (out of range):
  - acked in 1 cycle.
  - No SRAM word changes.
